frame_config_ctrl: RTL

- Configuration frame controller for the eFPGA fabric.
- Takes a 32-bit configuration word stream from the config port, assembles frame data for every tile row, and pulses exactly one FrameStrobe line per frame.
- The strobe goes to the selected column and frame.
- Drives the FrameData/FrameStrobe bundles feeding the terminal and fabric tiles.
- Each column chain, terminated at the south by the term tiles, receives FrameStrobe[MaxFramesPerCol-1:0] for that column.

---
 rtl/frame_cfg_pkg.sv | 41 ++++
 rtl/frame_strobe_decode.sv | 49 ++++
 rtl/frame_config_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/frame_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_cfg_pkg
// Brief    : Shared types and address-word field positions for the eFPGA
//            configuration frame controller.
// Revision : 1.0
// ============================================================================
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int END_BIT = 31;
    localparam int COL_MSB = 23;
    localparam int COL_LSB = 16;
    localparam int FRM_MSB = 4;
    localparam int FRM_LSB = 0;

    localparam int COL_W  = COL_MSB - COL_LSB + 1;
    localparam int FRM_W  = FRM_MSB - FRM_LSB + 1;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] SYNC_WORD = 32'hFAB0_FAB1;

    // True when the addressed column/frame exists in this fabric instance.
    function automatic logic addr_in_range(
        input logic [COL_W-1:0] col,
        input logic [FRM_W-1:0] frm,
        input int               num_cols,
        input int               num_frames
    );
        return (int'(col) < num_cols) && (int'(frm) < num_frames);
    endfunction

endpackage : frame_cfg_pkg
`default_nettype wire

// File: rtl/frame_strobe_decode.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_decode
// Brief    : Registered one-hot decoder from (column, frame, enable) to the
//            flat FrameStrobe vector; all strobes clear on reset.
// Revision : 1.0
// ============================================================================
module frame_strobe_decode
    import frame_cfg_pkg::*;
#(
    parameter int NUM_COLUMNS        = 4,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_en,
    input  logic [COL_W-1:0]                          i_col,
    input  logic [FRM_W-1:0]                          i_frame,
    output logic [MAX_FRAMES_PER_COL*NUM_COLUMNS-1:0] o_strobe
);

    localparam int c_STROBE_W = MAX_FRAMES_PER_COL * NUM_COLUMNS;

    logic [c_STROBE_W-1:0] w_hit;
    logic [c_STROBE_W-1:0] r_strobe;

    // Each bit matches exactly one (col, frame) pair, so at most one bit of
    // w_hit can ever be set.
    for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_col
        for (genvar f = 0; f < MAX_FRAMES_PER_COL; f++) begin : g_frm
            assign w_hit[c*MAX_FRAMES_PER_COL + f] =
                (i_col == COL_W'(c)) && (i_frame == FRM_W'(f));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= '0;
        end else if (i_en) begin
            r_strobe <= w_hit;
        end else begin
            r_strobe <= '0;
        end
    end

    assign o_strobe = r_strobe;

endmodule : frame_strobe_decode
`default_nettype wire

// File: rtl/frame_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_ctrl
// Brief    : Configuration frame controller: parses sync/address/data words
//            from the config port and strobes one frame line per frame.
// Revision : 1.0
// ============================================================================
module frame_config_ctrl
    import frame_cfg_pkg::*;
#(
    parameter int                NUM_COLUMNS        = 4,
    parameter int                NUM_ROWS           = 2,
    parameter int                MAX_FRAMES_PER_COL = 20,
    parameter int                FRAME_BITS_PER_ROW = 32,
    parameter int                STROBE_WIDTH       = 1,
    parameter logic [WORD_W-1:0] SYNC_VALUE         = SYNC_WORD
) (
    input  logic                                         CLK,
    input  logic                                         reset,
    input  logic [WORD_W-1:0]                            s_data,
    input  logic                                         s_valid,
    output logic                                         s_ready,
    output logic [FRAME_BITS_PER_ROW*NUM_ROWS-1:0]       FrameData,
    output logic [MAX_FRAMES_PER_COL*NUM_COLUMNS-1:0]    FrameStrobe,
    output logic                                         busy,
    output logic                                         cfg_done,
    output logic                                         err_addr,
    output logic [15:0]                                  frame_count
);

    localparam int         c_ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [3:0] c_SW_LAST = 4'(STROBE_WIDTH - 1);

    state_t                                   r_state;
    logic [c_ROW_W-1:0]                       r_row_cnt;
    logic [COL_W-1:0]                         r_col;
    logic [FRM_W-1:0]                         r_frame;
    logic                                     r_discard;
    logic [3:0]                               r_strobe_cnt;
    logic [FRAME_BITS_PER_ROW*NUM_ROWS-1:0]   r_frame_data;
    logic                                     r_cfg_done;
    logic                                     r_err_addr;
    logic [15:0]                              r_frame_count;

    logic                                     w_accept;
    logic                                     w_last_row;
    logic                                     w_addr_end;
    logic [COL_W-1:0]                         w_addr_col;
    logic [FRM_W-1:0]                         w_addr_frm;
    logic                                     w_strobe_en;

    always_comb begin
        s_ready     = (r_state == IDLE) || (r_state == ADDR) || (r_state == DATA);
        w_accept    = s_valid && s_ready;
        w_last_row  = (r_row_cnt == c_ROW_W'(NUM_ROWS - 1));
        w_addr_end  = s_data[END_BIT];
        w_addr_col  = s_data[COL_MSB:COL_LSB];
        w_addr_frm  = s_data[FRM_MSB:FRM_LSB];
        // Decoder output is registered, so request the strobe one cycle
        // ahead: on the last data handshake and while the window continues.
        w_strobe_en = ((r_state == DATA) && w_accept && w_last_row && !r_discard) ||
                      ((r_state == STROBE) && (r_strobe_cnt != c_SW_LAST));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= IDLE;
            r_row_cnt     <= '0;
            r_col         <= '0;
            r_frame       <= '0;
            r_discard     <= 1'b0;
            r_strobe_cnt  <= '0;
            r_frame_data  <= '0;
            r_cfg_done    <= 1'b0;
            r_err_addr    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_cfg_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && (s_data == SYNC_VALUE)) begin
                        r_state       <= ADDR;
                        r_err_addr    <= 1'b0;
                        r_frame_count <= '0;
                    end
                end
                ADDR: begin
                    if (w_accept) begin
                        if (w_addr_end) begin
                            r_cfg_done <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_col     <= w_addr_col;
                            r_frame   <= w_addr_frm;
                            r_row_cnt <= '0;
                            r_state   <= DATA;
                            if (addr_in_range(w_addr_col, w_addr_frm,
                                              NUM_COLUMNS, MAX_FRAMES_PER_COL)) begin
                                r_discard <= 1'b0;
                            end else begin
                                r_discard  <= 1'b1;
                                r_err_addr <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        for (int r = 0; r < NUM_ROWS; r++) begin
                            if (r_row_cnt == c_ROW_W'(r)) begin
                                r_frame_data[r*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] <= s_data;
                            end
                        end
                        if (w_last_row) begin
                            if (r_discard) begin
                                r_state <= ADDR;
                            end else begin
                                r_state      <= STROBE;
                                r_strobe_cnt <= '0;
                                if (r_frame_count != 16'hFFFF) begin
                                    r_frame_count <= r_frame_count + 16'd1;
                                end
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + c_ROW_W'(1);
                        end
                    end
                end
                STROBE: begin
                    if (r_strobe_cnt == c_SW_LAST) begin
                        r_state <= GAP;
                    end else begin
                        r_strobe_cnt <= r_strobe_cnt + 4'd1;
                    end
                end
                GAP: begin
                    r_state <= ADDR;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    frame_strobe_decode #(
        .NUM_COLUMNS        (NUM_COLUMNS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL)
    ) u_strobe_decode (
        .clk      (CLK),
        .rst      (reset),
        .i_en     (w_strobe_en),
        .i_col    (r_col),
        .i_frame  (r_frame),
        .o_strobe (FrameStrobe)
    );

    assign FrameData   = r_frame_data;
    assign busy        = (r_state != IDLE);
    assign cfg_done    = r_cfg_done;
    assign err_addr    = r_err_addr;
    assign frame_count = r_frame_count;

endmodule : frame_config_ctrl
`default_nettype wire
